// File: rtl/mr_wb_timer_pkg.sv
// mr_wb_timer_pkg: shared types, register map and helpers for the Wishbone machine timer
package mr_wb_timer_pkg;
  localparam int XLEN = 32;
  localparam int XLEN_GRAN = 2;
  localparam int CTRL_EN_BIT = 0;
  localparam int REG_COUNT = 6;
  localparam logic [63:0] MTIMECMP_RST = '1;
  typedef enum logic [2:0] {
    R_MTIME_LO,
    R_MTIME_HI,
    R_MTIMECMP_LO,
    R_MTIMECMP_HI,
    R_CTRL,
    R_PRESCALE
  } e_timer_reg;
  typedef enum logic [1:0] {RS_IDLE, RS_WAIT, RS_RESP} e_resp_state;
  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old, input logic [XLEN-1:0] wdat,
                                                 input logic [XLEN/8-1:0] sel);
    logic [XLEN-1:0] r;
    for (int b = 0; b < XLEN/8; b++) r[8*b +: 8] = sel[b] ? wdat[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/wb_slave_resp.sv
// wb_slave_resp: pipelined Wishbone slave handshake with optional wait states and cyc abort
module wb_slave_resp
  import mr_wb_timer_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cyc_i,
  input  logic stb_i,
  input  logic valid,
  output logic accept,
  output logic cap,
  output logic ack_o,
  output logic err_o,
  output logic stall_o
);
  if (WAIT_STATES == 0) begin : g_zero
    logic ack_q, err_q;
    assign stall_o = 1'b0;
    assign accept = cyc_i && stb_i;
    assign cap = accept;
    assign ack_o = ack_q;
    assign err_o = err_q;
    always_ff @(posedge clk_i) begin
      ack_q <= !rst_i && accept && valid;
      err_q <= !rst_i && accept && !valid;
    end
  end else begin : g_wait
    localparam int CW = $clog2(WAIT_STATES + 1);
    e_resp_state state, nxt;
    logic [CW-1:0] cnt;
    logic valid_q, done;
    always_comb begin
      done = cnt == CW'(WAIT_STATES - 1);
      stall_o = state == RS_WAIT;
      accept = cyc_i && stb_i && !stall_o;
      cap = stall_o && cyc_i && done;
      ack_o = state == RS_RESP && cyc_i && valid_q;
      err_o = state == RS_RESP && cyc_i && !valid_q;
      nxt = state == RS_WAIT ? (!cyc_i ? RS_IDLE : done ? RS_RESP : RS_WAIT) : accept ? RS_WAIT : RS_IDLE;
    end
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state <= RS_IDLE;
        cnt <= '0;
        valid_q <= 1'b0;
      end else begin
        state <= nxt;
        cnt <= state == RS_WAIT ? cnt + CW'(1) : '0;
        if (accept) valid_q <= valid;
      end
    end
  end
endmodule

// File: rtl/mr_wb_timer.sv
// mr_wb_timer: Wishbone B4 pipelined slave with prescaled 64-bit mtime, mtimecmp and registered irq
module mr_wb_timer
  import mr_wb_timer_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int ADDR_BITS = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [XLEN-XLEN_GRAN-1:0] addr_i,
  input  logic                      we_i,
  input  logic [XLEN/8-1:0]         sel_i,
  input  logic [XLEN-1:0]           dat_i,
  input  logic                      stb_i,
  input  logic                      cyc_i,
  output logic                      ack_o,
  output logic                      err_o,
  output logic [XLEN-1:0]           dat_o,
  output logic                      stall_o,
  output logic                      irq_o
);
  logic [63:0] mtime, mtimecmp;
  logic [XLEN-1:0] prescale, pcnt, dat_q, wr_old, merged, rdata;
  logic en, accept, cap, valid, wr, clr, tick, unused_addr;
  logic [ADDR_BITS-1:0] idx, idx_q, rd_idx;
  e_timer_reg wreg, rreg;
  assign idx = addr_i[ADDR_BITS-1:0];
  assign unused_addr = ^addr_i[XLEN-XLEN_GRAN-1:ADDR_BITS];
  assign valid = 32'(idx) < 32'(REG_COUNT);
  assign rd_idx = WAIT_STATES == 0 ? idx : idx_q;
  assign wreg = e_timer_reg'(idx[2:0]);
  assign rreg = e_timer_reg'(rd_idx[2:0]);
  assign wr = accept && we_i && valid;
  assign clr = wr && |sel_i && (wreg == R_CTRL || wreg == R_PRESCALE);
  assign tick = en && pcnt == prescale;
  assign dat_o = ack_o ? dat_q : '0;
  always_comb begin
    rdata = rreg == R_MTIME_LO ? mtime[31:0] :
            rreg == R_MTIME_HI ? mtime[63:32] :
            rreg == R_MTIMECMP_LO ? mtimecmp[31:0] :
            rreg == R_MTIMECMP_HI ? mtimecmp[63:32] :
            rreg == R_CTRL ? XLEN'(en) << CTRL_EN_BIT :
            rreg == R_PRESCALE ? prescale : '0;
    wr_old = wreg == R_MTIME_LO ? mtime[31:0] :
             wreg == R_MTIME_HI ? mtime[63:32] :
             wreg == R_MTIMECMP_LO ? mtimecmp[31:0] :
             wreg == R_MTIMECMP_HI ? mtimecmp[63:32] : prescale;
    merged = byte_merge(wr_old, dat_i, sel_i);
  end
  wb_slave_resp #(.WAIT_STATES(WAIT_STATES)) u_resp (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .cyc_i(cyc_i),
    .stb_i(stb_i),
    .valid(valid),
    .accept(accept),
    .cap(cap),
    .ack_o(ack_o),
    .err_o(err_o),
    .stall_o(stall_o)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime <= '0;
      mtimecmp <= MTIMECMP_RST;
      en <= 1'b0;
      prescale <= '0;
      pcnt <= '0;
      irq_o <= 1'b0;
      dat_q <= '0;
      idx_q <= '0;
    end else begin
      irq_o <= en && mtime >= mtimecmp;
      if (accept) idx_q <= idx;
      if (cap) dat_q <= rdata;
      pcnt <= clr || tick ? '0 : en ? pcnt + XLEN'(1) : pcnt;
      mtime <= wr && wreg == R_MTIME_LO ? {mtime[63:32], merged} :
               wr && wreg == R_MTIME_HI ? {merged, mtime[31:0]} :
               tick ? mtime + 64'd1 : mtime;
      if (wr && wreg == R_MTIMECMP_LO) mtimecmp[31:0] <= merged;
      if (wr && wreg == R_MTIMECMP_HI) mtimecmp[63:32] <= merged;
      if (wr && wreg == R_CTRL && sel_i[CTRL_EN_BIT/8]) en <= dat_i[CTRL_EN_BIT];
      if (wr && wreg == R_PRESCALE) prescale <= merged;
    end
  end
endmodule

// File: doc/mr_wb_timer.md
Name: mr_wb_timer

Overview:
- Pipelined Wishbone B4 slave: the responder end of the bus that the ifetch/ldst masters drive through the arbiter.
- Holds a 64-bit free-running machine timer (mtime) with a prescaler, and a 64-bit compare register (mtimecmp).
- Raises a registered interrupt request when the timer reaches the compare value.
- Sits beside simple_mem behind the arbiter/address decode and has the same slave port shape.

Parameters:
- WAIT_STATES, 0, extra cycles the slave stalls per accepted request (0 = single-cycle ack, back-to-back capable).
- ADDR_BITS, 3, low word-address bits decoded; upper bits are ignored (aliasing allowed).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- addr_i  in  XLEN-XLEN_GRAN  word address.
- we_i  in  1  write enable.
- sel_i  in  XLEN/8  byte lane select.
- dat_i  in  XLEN  write data.
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle.
- ack_o  out  1  acknowledge.
- err_o  out  1  error (bad address).
- dat_o  out  XLEN  read data.
- stall_o  out  1  stall.
- irq_o  out  1  timer interrupt request.

Behaviour:
- Register map (word index): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 EN, others read 0), 5 PRESCALE (full word). Indices 6..7 are invalid.
- Reset values: mtime=0, mtimecmp=all-ones, CTRL=0, PRESCALE=0, prescale counter=0, ack_o=0, err_o=0, stall_o=0, dat_o=0, irq_o=0. A reset mid-transaction drops any pending response, with no ack/err.
- Acceptance: a request is accepted on an edge where cyc_i && stb_i && !stall_o.
- Writes commit at the acceptance edge, byte-merged per sel_i; sel_i=0 is a no-op write that is still acked.
- Read data is captured at the acceptance edge for WAIT_STATES=0. For WAIT_STATES>0 it is captured at the response edge.
- FSM IDLE/WAIT/RESP:
  - WAIT_STATES=0: IDLE only. The response (ack_o or err_o) is asserted exactly 1 cycle after acceptance. stall_o is held 0, so one request per cycle is accepted with acks pipelined.
  - WAIT_STATES=N>0: acceptance moves IDLE to WAIT. stall_o=1 from the next cycle; a counter runs N cycles. The FSM then enters RESP: ack_o/err_o high for one cycle, stall_o=0 in that cycle, then back to IDLE.
  - Latency is 1+N cycles.
- A response pulse lasts exactly one cycle. ack_o and err_o are never both high. dat_o is 0 whenever ack_o=0.
- Invalid index: err_o is asserted instead of ack_o with identical timing. No state changes; dat_o=0.
- cyc_i low while WAIT/RESP is pending aborts the response: no ack/err, return to IDLE. A write that already committed stays committed.
- Prescaler and increment:
  - When EN=1, the prescale counter increments each cycle.
  - When the counter equals PRESCALE it clears and mtime increments by 1. PRESCALE=0 gives one increment per cycle.
  - mtime wraps from 2^64-1 to 0.
  - When EN=0 the counter holds.
- Writing PRESCALE or CTRL clears the prescale counter.
- Write vs tick in the same cycle: the mtime write wins. The written half takes the merged bytes, the other half holds its old value, and that tick is lost (no carry).
- irq_o is registered: irq_o <= EN && (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on pre-edge values. It lags register updates by 1 cycle. There is no clear register; software rewrites mtimecmp.
- Read of MTIME_HI returns the live value. There is no LO/HI snapshot latch; software uses the hi/lo/hi read sequence.

Decomposition:
- Shared package (alongside e_memops etc.):
  - enum e_timer_reg for word indices 0..5.
  - CTRL_EN_BIT constant.
  - MTIMECMP reset constant.
- Sub-module wb_slave_resp: the generic acceptance/wait-state/abort FSM producing accept, ack/err pulses and stall_o. It is parameterised by WAIT_STATES and reusable by future MMIO slaves. The timer core instantiates it and supplies the decode-valid and read data.

Test Plan:
- Reset, then read index 3, WAIT_STATES=0 -> ack_o at cycle+1 with dat_o=0xFFFFFFFF; err_o=0, stall_o=0 throughout.
- Write PRESCALE=3 then CTRL=1 (sel=1111) -> MTIME_LO reads 0,1,2 at 4-cycle spacing. Also do back-to-back stb on 3 consecutive cycles -> 3 consecutive acks.
- Write MTIMECMP_LO=5, MTIMECMP_HI=0, PRESCALE=0, EN=1 from mtime=0 -> irq_o rises exactly 1 cycle after mtime becomes 5. Rewriting MTIMECMP_HI=1 drops irq_o 1 cycle later.
- WAIT_STATES=2: single read -> stall_o high for 2 cycles, ack at acceptance+3. Deassert cyc_i during the stall -> no ack, next request served normally.
- Write index 6 -> err_o pulse at cycle+1, no ack, all registers unchanged. Write MTIME_LO=0xFFFFFFFF, MTIME_HI=0xFFFFFFFF with EN=1 -> wraps to 0 and MTIME_HI reads 0.
- Write MTIME_LO with sel=0011, data 0xAAAA_BBBB, colliding with a tick -> low 16 bits are 0xBBBB, upper bytes keep their prior value, no increment that cycle. Assert rst_i while a WAIT_STATES=2 request is pending -> no ack, all outputs at reset values next cycle.
